// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: 2-bit BHT predict at F, resolve and train at D.
// Optional BPRED_STATS_EN adds saturating resolve/mispredict counters.
module branch_pred_ctrl #(
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic        f_is_branch,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    input  logic        d_stall,
    input  logic        d_resolve,
    input  logic [31:0] d_pc,
    input  logic        d_branch,
    input  logic [31:0] d_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int N = 1 << IDX_W;

    logic [1:0]       bht [N];
    logic [IDX_W-1:0] fidx;
    logic [IDX_W-1:0] widx;
    logic             wr_en;
    logic [1:0]       cur;
    logic [1:0]       nxt;
    logic [1:0]       rd;
    logic             pend_taken;

    assign fidx  = f_pc[IDX_W+1:2];
    assign widx  = d_pc[IDX_W+1:2];
    assign wr_en = d_resolve & ~d_stall;

    always_comb begin
        cur = bht[widx];
        nxt = cur;
        if (d_branch) begin
            if (cur != 2'b11) nxt = cur + 2'd1;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'd1;
        end
    end

    // Same-index training this cycle is forwarded into the prediction.
    always_comb begin
        rd = bht[fidx];
        if (wr_en && (widx == fidx)) rd = nxt;
    end

    always_comb begin
        pred_taken  = reset & f_valid & f_is_branch & rd[1];
        mispredict  = reset & d_resolve & (d_branch != pend_taken);
        redirect_pc = '0;
        if (reset) redirect_pc = d_branch ? d_target : d_pc + 32'd8;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) bht[i] <= CNT_INIT;
        end else if (wr_en) begin
            bht[widx] <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_taken <= 1'b0;
        end else if (!d_stall) begin
            pend_taken <= pred_taken;
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (d_resolve && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispred != 32'hFFFF_FFFF)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: directed plan plus random traffic vs a table model.
// Define BPRED_STATS_EN to also check the statistics counters.
module tb_branch_pred_ctrl;

    localparam int IDX_W = 6;
    localparam int N     = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid;
    logic        f_is_branch;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic        d_stall;
    logic        d_resolve;
    logic [31:0] d_pc;
    logic        d_branch;
    logic [31:0] d_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          m_cnt [N];
    bit          m_pend;
    logic [31:0] m_nb;
    logic [31:0] m_nm;

    always #5 clk = ~clk;

    branch_pred_ctrl #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
        .clk         (clk),
        .reset       (reset),
        .f_valid     (f_valid),
        .f_is_branch (f_is_branch),
        .f_pc        (f_pc),
        .pred_taken  (pred_taken),
        .d_stall     (d_stall),
        .d_resolve   (d_resolve),
        .d_pc        (d_pc),
        .d_branch    (d_branch),
        .d_target    (d_target),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc)
`ifdef BPRED_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input bit up);
        if (up) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int pidx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 1;
        m_pend = 1'b0;
        m_nb   = '0;
        m_nm   = '0;
    endtask

    // Expected outputs from the current inputs and model state.
    task automatic expect_now(output bit ep, output bit em,
                              output logic [31:0] er);
        int c;
        c = m_cnt[pidx(f_pc)];
        if (d_resolve && !d_stall && pidx(d_pc) == pidx(f_pc))
            c = sat(c, d_branch);
        ep = reset && f_valid && f_is_branch && (c >= 2);
        em = reset && d_resolve && (d_branch != m_pend);
        if (!reset) er = '0;
        else        er = d_branch ? d_target : d_pc + 32'd8;
    endtask

    // One full cycle: compare at negedge+1, advance model at posedge.
    task automatic step();
        bit          ep;
        bit          em;
        logic [31:0] er;
        #1;
        if (!reset) model_reset();
        expect_now(ep, em, er);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, ep});
        chk("mispredict", {31'd0, mispredict}, {31'd0, em});
        chk("redirect_pc", redirect_pc, er);
`ifdef BPRED_STATS_EN
        chk("stat_branches", stat_branches, m_nb);
        chk("stat_mispred", stat_mispred, m_nm);
`endif
        @(posedge clk);
        if (reset) begin
            if (d_resolve && !d_stall)
                m_cnt[pidx(d_pc)] = sat(m_cnt[pidx(d_pc)], d_branch);
            if (!d_stall) m_pend = ep;
            if (d_resolve && m_nb != 32'hFFFF_FFFF) m_nb = m_nb + 1;
            if (em && m_nm != 32'hFFFF_FFFF) m_nm = m_nm + 1;
        end
        @(negedge clk);
    endtask

    task automatic drive_f(input bit v, input bit b, input logic [31:0] pc);
        f_valid     = v;
        f_is_branch = b;
        f_pc        = pc;
    endtask

    task automatic drive_d(input bit st, input bit res, input logic [31:0] pc,
                           input bit br, input logic [31:0] tgt);
        d_stall   = st;
        d_resolve = res;
        d_pc      = pc;
        d_branch  = br;
        d_target  = tgt;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        drive_f(1, 1, 32'h3000);
        drive_d(0, 1, 32'h3000, 1, 32'h3040);
        #1;
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_mis", {31'd0, mispredict}, 32'd0);
        chk("rst_redir", redirect_pc, 32'd0);
        step();

        reset = 1'b1;
        drive_d(0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("first_pred_nt", {31'd0, pred_taken}, 32'd0);
        step();

        drive_f(0, 0, 32'h3004);
        drive_d(0, 1, 32'h3000, 1, 32'h3040);
        #1;
        chk("first_mis", {31'd0, mispredict}, 32'd1);
        chk("first_redir", redirect_pc, 32'h3040);
        step();

        drive_f(1, 1, 32'h3000);
        drive_d(0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("second_pred_t", {31'd0, pred_taken}, 32'd1);
        step();
        drive_f(0, 0, 32'h3004);
        drive_d(0, 1, 32'h3000, 1, 32'h3040);
        #1;
        chk("second_mis", {31'd0, mispredict}, 32'd0);
        step();

        drive_f(1, 1, 32'h3000);
        drive_d(0, 0, 32'h0, 0, 32'h0);
        step();
        drive_f(0, 0, 32'h3004);
        drive_d(0, 1, 32'h3000, 1, 32'h3040);
        step();

        drive_f(1, 1, 32'h3000);
        drive_d(0, 0, 32'h0, 0, 32'h0);
        step();
        drive_f(1, 1, 32'h3000);
        drive_d(0, 1, 32'h3000, 0, 32'h3040);
        #1;
        chk("nt_mis", {31'd0, mispredict}, 32'd1);
        chk("nt_redir", redirect_pc, 32'h3008);
        chk("sat_pred_still_t", {31'd0, pred_taken}, 32'd1);
        step();

        drive_f(1, 0, 32'h4000);
        drive_d(1, 0, 32'h0, 0, 32'h0);
        repeat (3) step();
        drive_f(0, 0, 32'h4004);
        drive_d(0, 1, 32'h3000, 1, 32'h3040);
        #1;
        chk("stall_hold_mis", {31'd0, mispredict}, 32'd0);
        step();

        drive_f(1, 1, 32'h3104);
        drive_d(0, 1, 32'h3004, 1, 32'h3100);
        #1;
        chk("bypass_pred", {31'd0, pred_taken}, 32'd1);
        chk("bypass_mis", {31'd0, mispredict}, 32'd1);
        step();

        drive_f(1, 1, 32'h3000);
        drive_d(0, 0, 32'h0, 0, 32'h0);
        #1;
        chk("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_pred", {31'd0, pred_taken}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_pred", {31'd0, pred_taken}, 32'd0);
`ifdef BPRED_STATS_EN
        chk("post_rst_nb", stat_branches, 32'd0);
        chk("post_rst_nm", stat_mispred, 32'd0);
`endif
        step();

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            f_valid     = $urandom_range(0, 3) != 0;
            f_is_branch = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) f_pc = $urandom;
            else f_pc = 32'h3000 + ($urandom_range(0, 127) << 2);
            d_stall   = $urandom_range(0, 3) == 0;
            d_resolve = !d_stall && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       d_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
                1:       d_pc = $urandom;
                default: d_pc = 32'h3000 + ($urandom_range(0, 127) << 2);
            endcase
            d_branch = $urandom_range(0, 2) != 0;
            d_target = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Dynamic branch-prediction controller that sequences the decode-stage branch comparator.
- Predicts conditional branches at fetch from a table of 2-bit saturating counters (BHT).
- Carries each prediction into D, checks it against the comparator's `Branch` result, raises mispredict with the corrected PC, and trains the table.
- Sits between the F-stage next-PC mux, the F/D pipeline register and the D-stage compare logic.

Parameters:
- IDX_W, 6, BHT index width; table holds 2**IDX_W entries indexed by pc[IDX_W+1:2].
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- f_valid  input  1  F stage holds a valid fetched instruction this cycle.
- f_is_branch  input  1  predecoded F instruction is a conditional branch (beq/bne/bgez/bgtz/blez/bltz/bgezal/bgezalr).
- f_pc  input  32  PC of the F instruction.
- pred_taken  output  1  prediction for the F instruction; the next-PC mux selects the F target when 1.
- d_stall  input  1  D stage stalled by hazard unit; F/D register holds.
- d_resolve  input  1  D instruction is a conditional branch and is not stalled this cycle.
- d_pc  input  32  PC of the D instruction.
- d_branch  input  1  comparator result for the D instruction (1 = taken).
- d_target  input  32  branch target of the D instruction.
- mispredict  output  1  D-stage prediction was wrong; the PC register loads redirect_pc.
- redirect_pc  output  32  corrected fetch PC.

Behaviour:
- Reset (reset=0, async): all BHT entries = CNT_INIT; pend_taken = 0; outputs pred_taken = 0, mispredict = 0, redirect_pc = 0.
- Prediction (combinational, F):
  - pred_taken = f_valid & f_is_branch & BHT[f_pc[IDX_W+1:2]][1].
  - Write bypass: if a training write to the same index happens this cycle, use the counter's new value.
- Pending register (F→D):
  - On a rising edge with d_stall=0: pend_taken <= pred_taken.
  - With d_stall=1: pend_taken holds, matching the F/D register.
- Resolution (combinational, D):
  - mispredict = d_resolve & (d_branch != pend_taken).
  - redirect_pc = d_branch ? d_target : d_pc + 8 (fall-through past the delay slot).
  - When mispredict=0, redirect_pc is don't-care but still driven by the same expression.
  - The delay slot in F is never squashed.
- Training (sequential):
  - On a rising edge with d_resolve=1, counter at d_pc[IDX_W+1:2] moves +1 if d_branch, -1 otherwise.
  - Saturates at 2'b11 and 2'b00; there is no wrap.
  - d_resolve=0 or d_stall=1 → no table write.
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; the prediction is bit[1].
- Simultaneous events:
  - Training and prediction on the same index in one cycle: the prediction sees the updated value via bypass.
  - d_resolve=1 together with d_stall=1 is illegal; the hazard unit guarantees it never occurs.
- Stall for multiple cycles: pend_taken stays stable; mispredict is evaluated only in the cycle d_resolve=1.
- Reset mid-operation: all training is lost and the table returns to CNT_INIT. A branch in flight resolves against pend_taken=0.
- All PC arithmetic is 32-bit unsigned and wraps modulo 2**32.

Optional Feature:
- Macro: BPRED_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] and stat_mispred[31:0], both reset to 0.
  - stat_branches increments on every edge with d_resolve=1.
  - stat_mispred increments on every edge with mispredict=1.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then f_valid=1, f_is_branch=1, f_pc=0x3000 → pred_taken=0. Next cycle: d_resolve=1, d_branch=1, d_pc=0x3000, d_target=0x3040 → mispredict=1, redirect_pc=0x3040; entry 0 becomes 10.
- Same branch again: pred_taken=1; resolve with d_branch=1 → mispredict=0; entry 0 becomes 11. A third taken resolve keeps it at 11 (saturation).
- Entry at 11, resolve not-taken with d_pc=0x3000 → mispredict=1, redirect_pc=0x3008; entry becomes 10 and the next prediction is still 1.
- pred_taken=1 captured, then d_stall=1 held 3 cycles with f_pc changing to a non-branch → pend_taken stays 1; release and resolve with d_branch=1 → mispredict=0.
- Same-cycle resolve (d_pc=0x3004, taken, entry 01→10) and predict (f_pc=0x3104, same index for IDX_W=6) → pred_taken=1 via bypass.
- Assert reset low mid-stream with entry 0 at 11 → pred_taken=0 immediately and entry 0 reads 01 after release. With BPRED_STATS_EN defined, both stat counters read 0 after release.
